// File: rtl/clk_div_arbiter.sv
// Round-robin shared interval timer: grants one requester at a time, counts
// its len+1 cycle interval down and pulses done back to that owner.
module clk_div_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy
);

  localparam int SW = $clog2(NREQ);
  localparam int unsigned N = NREQ;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);
  localparam logic [SW-1:0] LAST = SW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t          state;
  logic [W-1:0]    count;
  logic [SW-1:0]   sel;
  logic [SW-1:0]   ptr;
  logic [SW-1:0]   winner;
  logic            found;
  logic [SW-1:0]   sel_next;
  logic [W-1:0]    len_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_len
    assign len_arr[g] = len[g*W +: W];
  end

  // Scan ptr, ptr+1, ... wrapping at NREQ; first set bit wins.
  always_comb begin
    int unsigned   k;
    logic [SW-1:0] idx;
    winner = ptr;
    found  = 1'b0;
    k      = 0;
    idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = 32'(ptr) + i;
      if (k >= N) k = k - N;
      idx = SW'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign sel_next = (sel == LAST) ? '0 : sel + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
      count <= '0;
      sel   <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel   <= winner;
            count <= len_arr[winner];
            gnt   <= ONE << winner;
            busy  <= 1'b1;
            state <= COUNT;
          end
        end
        COUNT: begin
          if (!req[sel]) begin
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= sel_next;
            state <= IDLE;
          end else if (count == '0) begin
            // gnt is already onehot(sel), so it doubles as the done mask.
            done  <= gnt;
            state <= DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE: begin
          gnt   <= '0;
          done  <= '0;
          busy  <= 1'b0;
          ptr   <= sel_next;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_arbiter.sv
// Randomised plus directed bench for clk_div_arbiter, checked against a
// transaction-level model (owner, grant cycle, length) and a done-event queue.
module tb_clk_div_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] len = '0;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              busy;

  clk_div_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .len (len),
    .gnt (gnt),
    .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct {int idx; int cyc;} ev_t;
  ev_t doneq[$];

  int cyc    = 0;
  int owner  = -1;
  int g_cyc  = 0;
  int L      = 0;
  int rr     = 0;
  bit armed  = 1'b0;

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
  endtask

  // Reference model: the owner holds the timer from grant cycle g for L+1
  // counting cycles, done arrives at g+L+1, release at g+L+2 (or on abort).
  always @(posedge clk) begin
    int k;
    if (rst) begin
      owner = -1;
      rr    = 0;
      armed = 1'b1;
    end else if (owner < 0) begin
      for (int i = 0; i < NREQ; i++) begin
        k = (rr + i) % NREQ;
        if (owner < 0 && req[k]) begin
          owner = k;
          g_cyc = cyc + 1;
          L     = int'(len[k*W +: W]);
        end
      end
    end else if (cyc <= g_cyc + L) begin
      if (!req[owner]) begin
        rr    = (owner + 1) % NREQ;
        owner = -1;
      end else if (cyc == g_cyc + L) begin
        doneq.push_back('{owner, cyc + 1});
      end
    end else begin
      rr    = (owner + 1) % NREQ;
      owner = -1;
    end
    cyc++;
  end

  // Monitor: per-cycle output compare plus done-event scoreboard.
  always @(negedge clk) begin
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] ed;
    ev_t e;
    if (armed) begin
      eg = (owner >= 0) ? oh(owner) : '0;
      ed = (owner >= 0 && cyc == g_cyc + L + 1) ? eg : '0;
      chk("gnt", 32'(gnt), 32'(eg));
      chk("busy", 32'(busy), 32'(owner >= 0));
      chk("done", 32'(done), 32'(ed));
      if (done != '0) begin
        if (doneq.size() == 0) begin
          checks++;
          $display("FAIL done_unexpected: got %b expected none (cycle %0d)", done, cyc);
        end else begin
          e = doneq.pop_front();
          chk("done_idx", 32'(done), 32'(oh(e.idx)));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        while (doneq.size() > 0 && doneq[0].cyc <= cyc) begin
          e = doneq.pop_front();
          checks++;
          $display("FAIL done_missing: got none expected req %0d at cycle %0d", e.idx, e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_len(input int i, input int v);
    len[i*W +: W] = W'(v);
  endtask

  task automatic wait_gnt(input logic [NREQ-1:0] mask, input int maxc);
    int n = 0;
    while ((gnt & mask) == '0 && n < maxc) begin
      tick(1);
      n++;
    end
    if ((gnt & mask) == '0) begin
      checks++;
      $display("FAIL wait_gnt: gnt=%b never hit %b within %0d cycles", gnt, mask, maxc);
    end
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (done == '0 && n < maxc) begin
      tick(1);
      n++;
    end
    if (done == '0) begin
      checks++;
      $display("FAIL wait_done: done=%b not seen within %0d cycles", done, maxc);
    end
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (busy && n < maxc) begin
      tick(1);
      n++;
    end
    if (busy) begin
      checks++;
      $display("FAIL wait_idle: busy=%b after %0d cycles", busy, maxc);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);

    // single requester, len 5
    set_len(0, 5);
    req = 4'b0001;
    wait_done(50);
    tick(1);
    req = '0;
    tick(3);

    // fairness with all lengths zero
    for (int i = 0; i < NREQ; i++) set_len(i, 0);
    req = 4'b1111;
    tick(24);
    req = '0;
    wait_idle(20);

    // boundary lengths
    req = 4'b0001;
    tick(6);
    req = '0;
    wait_idle(20);
    set_len(1, 255);
    req = 4'b0010;
    wait_done(300);
    req = '0;
    wait_idle(20);

    // abort on 5th count cycle, no pre-emption by newly raised bits
    set_len(0, 1); set_len(1, 1); set_len(2, 20); set_len(3, 2);
    req = 4'b0100;
    wait_gnt(4'b0100, 20);
    tick(4);
    req = 4'b1011;
    tick(30);
    req = '0;
    wait_idle(40);

    // mid-interval request from another bit
    set_len(0, 10);
    req = 4'b0001;
    wait_gnt(4'b0001, 20);
    tick(3);
    req = 4'b0011;
    tick(15);
    req = '0;
    wait_idle(40);

    // reset while counting (count = 7)
    set_len(0, 20);
    req = 4'b0001;
    wait_gnt(4'b0001, 20);
    tick(13);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req = 4'b1111;
    tick(10);
    req = '0;
    wait_idle(40);

    // reset during done
    set_len(0, 2);
    req = 4'b0001;
    wait_done(20);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req = 4'b1111;
    tick(8);
    req = '0;
    wait_idle(40);

    // len change after grant has no effect
    set_len(0, 3);
    req = 4'b0001;
    wait_gnt(4'b0001, 20);
    set_len(0, 9);
    wait_done(20);
    req = '0;
    wait_idle(20);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
      if ($urandom_range(0, 7) == 0) set_len($urandom_range(0, NREQ-1), $urandom_range(0, 12));
      rst = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    rst = 1'b0;
    req = '0;
    wait_idle(40);
    tick(4);

    checks++;
    if (doneq.size() == 0) passes++;
    else $display("FAIL doneq_drain: got %0d pending expected 0", doneq.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
